// File: rtl/alu_arbiter_pkg.sv
// alu_pkg: shared ALU definitions for the ALU arbiter slice.
//   - opcode constants ALU_ADD .. ALU_SLT and ALU_OP_LAST (highest legal code)
//   - FSM state type and state constants IDLE / EXEC / RESP
//   - op_legal(): opcode legality check used when an operation is captured
package alu_pkg;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_NOT     = 4'b0010;
    localparam logic [3:0] ALU_SLL     = 4'b0011;
    localparam logic [3:0] ALU_SRL     = 4'b0100;
    localparam logic [3:0] ALU_AND     = 4'b0101;
    localparam logic [3:0] ALU_OR      = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_OP_LAST = 4'b0111;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

    // Codes above ALU_OP_LAST are reserved and must never reach the ALU.
    function automatic logic op_legal(input logic [3:0] op);
        return (op <= ALU_OP_LAST);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two request channels, the response channel and
// the shared-ALU connection of the arbiter.
//   modport master : requesters, response consumer and the ALU itself
//   modport slave  : the arbiter
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req_op0;
    logic [3:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;
    logic [4:0]       req_sh0;
    logic [4:0]       req_sh1;

    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [3:0]       alu_cnt;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;
    logic             resp_zero;
    logic             resp_err;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
               req_sh0, req_sh1, alu_result, alu_zero, resp_ready,
        input  req_ready, alu_in1, alu_in2, alu_cnt, alu_shamt,
               resp_valid, resp_id, resp_data, resp_zero, resp_err
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
               req_sh0, req_sh1, alu_result, alu_zero, resp_ready,
        output req_ready, alu_in1, alu_in2, alu_cnt, alu_shamt,
               resp_valid, resp_id, resp_data, resp_zero, resp_err
    );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way grant logic for the ALU arbiter.
//   req   : request bits, bit i = requester i
//   last  : id of the most recently granted requester
//   grant : one-hot grant (zero when nothing requests)
// Macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties);
// otherwise a tie goes to the requester that is not 'last'.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_s;
    assign unused_last_s = last;

    // Fixed priority: requester 0 wins whenever it is requesting.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = 2'b01;
            default: grant = 2'b00;
        endcase
    end
`else
    // Round robin: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// One operation in flight: accept (IDLE) -> drive ALU (EXEC, one cycle) ->
// hold response until taken (RESP).
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_arbiter_if.slave (requests, ALU connection, response)
// Macro ALU_ARB_FIXED_PRIO_EN: fixed priority instead of round robin
// (the 'last' register is then not built).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    state_t           state_r;
    logic [1:0]       grant_s;
    logic             last_s;
    logic             accept_s;
    logic [3:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [4:0]       sel_sh_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [4:0]       sh_r;
    logic [3:0]       cnt_r;
    logic             err_r;
    logic             id_r;
    logic             resp_valid_r;
    logic             resp_id_r;
    logic [WIDTH-1:0] resp_data_r;
    logic             resp_zero_r;
    logic             resp_err_r;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign last_s = 1'b1;
`else
    logic last_r;
    assign last_s = last_r;

    // Remember who won the last accept; reset to 1 so requester 0 wins first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (accept_s) begin
            last_r <= grant_s[1];
        end
    end
`endif

    rr_arb2 u_arb (
        .req   (bus.req_valid),
        .last  (last_s),
        .grant (grant_s)
    );

    assign accept_s = (state_r == IDLE) && (grant_s != 2'b00);

    // Grant is only visible while idle; independent of the response side.
    always_comb begin
        if (state_r == IDLE) begin
            bus.req_ready = grant_s;
        end else begin
            bus.req_ready = 2'b00;
        end
    end

    // Select the winning requester's operation fields.
    always_comb begin
        if (grant_s[1]) begin
            sel_op_s = bus.req_op1;
            sel_a_s  = bus.req_a1;
            sel_b_s  = bus.req_b1;
            sel_sh_s = bus.req_sh1;
        end else begin
            sel_op_s = bus.req_op0;
            sel_a_s  = bus.req_a0;
            sel_b_s  = bus.req_b0;
            sel_sh_s = bus.req_sh0;
        end
    end

    // Operation FSM: capture on accept, sample ALU after EXEC, hold until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            a_r          <= '0;
            b_r          <= '0;
            sh_r         <= 5'd0;
            cnt_r        <= 4'd0;
            err_r        <= 1'b0;
            id_r         <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_data_r  <= '0;
            resp_zero_r  <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= sel_a_s;
                        b_r     <= sel_b_s;
                        sh_r    <= sel_sh_s;
                        // Illegal codes still run the ALU, but as a harmless add.
                        cnt_r   <= op_legal(sel_op_s) ? sel_op_s : ALU_ADD;
                        err_r   <= ~op_legal(sel_op_s);
                        id_r    <= grant_s[1];
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    resp_id_r    <= id_r;
                    resp_data_r  <= err_r ? '0 : bus.alu_result;
                    resp_zero_r  <= err_r ? 1'b0 : bus.alu_zero;
                    resp_err_r   <= err_r;
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_in1    = a_r;
    assign bus.alu_in2    = b_r;
    assign bus.alu_cnt    = cnt_r;
    assign bus.alu_shamt  = sh_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_zero  = resp_zero_r;
    assign bus.resp_err   = resp_err_r;

endmodule
